// File: rtl/dpi_flow_ctx_if.sv
// Stream, matcher and match-event signals of the per-flow DFA context manager.
// The DUT attaches through the slave modport; the environment drives through master.
interface dpi_flow_ctx_if #(
  parameter int FLOW_W  = 4,
  parameter int STATE_W = 11
);
  logic [7:0]         s_byte;
  logic [FLOW_W-1:0]  s_flow;
  logic               s_sop;
  logic               s_eop;
  logic               s_vld;
  logic               s_rdy;
  logic [7:0]         dfa_char;
  logic               dfa_char_vld;
  logic [STATE_W-1:0] dfa_state;
  logic               dfa_state_vld;
  logic [STATE_W-1:0] dfa_state_out;
  logic               dfa_accept;
  logic               ctx_clr;
  logic               match_vld;
  logic [FLOW_W-1:0]  match_flow;
  logic [15:0]        match_offset;
  logic               busy;

  modport slave (
    input  s_byte, s_flow, s_sop, s_eop, s_vld,
    output s_rdy,
    output dfa_char, dfa_char_vld, dfa_state, dfa_state_vld,
    input  dfa_state_out, dfa_accept,
    input  ctx_clr,
    output match_vld, match_flow, match_offset, busy
  );

  modport master (
    output s_byte, s_flow, s_sop, s_eop, s_vld,
    input  s_rdy,
    input  dfa_char, dfa_char_vld, dfa_state, dfa_state_vld,
    output dfa_state_out, dfa_accept,
    output ctx_clr,
    input  match_vld, match_flow, match_offset, busy
  );
endinterface

// File: rtl/dpi_flow_ctx.sv
// Per-flow DFA context manager: restores/saves matcher state around each packet.
// Define DPI_FLOW_CTX_MATCH_OFFSET_EN to include the per-packet match offset counter.
module dpi_flow_ctx #(
  parameter int FLOW_W  = 4,
  parameter int STATE_W = 11
) (
  input  logic          clk,
  input  logic          rst,
  dpi_flow_ctx_if.slave io
);
  localparam int NUM_CTX = 1 << FLOW_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_SAVE   = 3'd4,
    ST_CLEAR  = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [FLOW_W-1:0]  cur_flow_q, cur_flow_d;
  logic               clr_pend_q, clr_pend_d;
  logic [FLOW_W-1:0]  clr_idx_q, clr_idx_d;
  logic [STATE_W-1:0] ctx_q [NUM_CTX];

  logic               s_rdy;
  logic               byte_acc;

  logic [7:0]         dfa_char_q, dfa_char_d;
  logic               dfa_char_vld_q, dfa_char_vld_d;
  logic [STATE_W-1:0] dfa_state_q, dfa_state_d;
  logic               dfa_state_vld_q, dfa_state_vld_d;
  logic               match_vld_q, match_vld_d;
  logic [FLOW_W-1:0]  match_flow_q, match_flow_d;
  logic               busy_q, busy_d;

  // Next-state and handshake decode; the SOP byte is held in IDLE and consumed in LOAD.
  always_comb begin
    state_d    = state_q;
    cur_flow_d = cur_flow_q;
    s_rdy      = 1'b0;
    byte_acc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_rdy = ~io.s_sop;
        if (clr_pend_q || io.ctx_clr) begin
          state_d = ST_CLEAR;
        end else if (io.s_vld && io.s_sop) begin
          state_d    = ST_LOAD;
          cur_flow_d = io.s_flow;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD, ST_STREAM: begin
        s_rdy    = 1'b1;
        byte_acc = io.s_vld;
        if (io.s_vld && io.s_eop) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        state_d = ST_SAVE;
      end
      ST_SAVE: begin
        if (clr_pend_q || io.ctx_clr) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_idx_q == FLOW_W'(NUM_CTX - 1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clear bookkeeping: entering CLEAR consumes any pending request.
  always_comb begin
    if (state_d == ST_CLEAR && state_q != ST_CLEAR) begin
      clr_pend_d = 1'b0;
    end else if (io.ctx_clr && state_q != ST_IDLE) begin
      clr_pend_d = 1'b1;
    end else begin
      clr_pend_d = clr_pend_q;
    end
    if (state_q == ST_CLEAR) begin
      clr_idx_d = clr_idx_q + FLOW_W'(1);
    end else begin
      clr_idx_d = {FLOW_W{1'b0}};
    end
  end

  // Matcher-facing and match-event next values.
  always_comb begin
    dfa_char_vld_d = byte_acc;
    if (byte_acc) begin
      dfa_char_d = io.s_byte;
    end else begin
      dfa_char_d = dfa_char_q;
    end
    dfa_state_vld_d = (state_d == ST_LOAD);
    if (state_d == ST_LOAD) begin
      dfa_state_d = ctx_q[cur_flow_d];
    end else begin
      dfa_state_d = dfa_state_q;
    end
    match_vld_d = io.dfa_accept & dfa_char_vld_q;
    if (match_vld_d) begin
      match_flow_d = cur_flow_q;
    end else begin
      match_flow_d = match_flow_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cur_flow_q      <= {FLOW_W{1'b0}};
      clr_pend_q      <= 1'b0;
      clr_idx_q       <= {FLOW_W{1'b0}};
      dfa_char_q      <= 8'h00;
      dfa_char_vld_q  <= 1'b0;
      dfa_state_q     <= {STATE_W{1'b0}};
      dfa_state_vld_q <= 1'b0;
      match_vld_q     <= 1'b0;
      match_flow_q    <= {FLOW_W{1'b0}};
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cur_flow_q      <= cur_flow_d;
      clr_pend_q      <= clr_pend_d;
      clr_idx_q       <= clr_idx_d;
      dfa_char_q      <= dfa_char_d;
      dfa_char_vld_q  <= dfa_char_vld_d;
      dfa_state_q     <= dfa_state_d;
      dfa_state_vld_q <= dfa_state_vld_d;
      match_vld_q     <= match_vld_d;
      match_flow_q    <= match_flow_d;
      busy_q          <= busy_d;
    end
  end

  // Context array: SAVE writes the matcher's final state, CLEAR sweeps one entry per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        ctx_q[i] <= {STATE_W{1'b0}};
      end
    end else if (state_q == ST_SAVE) begin
      ctx_q[cur_flow_q] <= io.dfa_state_out;
    end else if (state_q == ST_CLEAR) begin
      ctx_q[clr_idx_q] <= {STATE_W{1'b0}};
    end
  end

`ifdef DPI_FLOW_CTX_MATCH_OFFSET_EN
  logic [15:0] off_q, off_d;
  logic [15:0] match_offset_q, match_offset_d;

  // off_q is the in-packet offset of the byte currently on dfa_char; saturates at 0xFFFF.
  always_comb begin
    if (state_q == ST_LOAD) begin
      off_d = 16'h0000;
    end else if (dfa_char_vld_q && off_q != 16'hFFFF) begin
      off_d = off_q + 16'h0001;
    end else begin
      off_d = off_q;
    end
    if (match_vld_d) begin
      match_offset_d = off_q;
    end else begin
      match_offset_d = match_offset_q;
    end
  end

  // Offset counter and registered match offset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q          <= 16'h0000;
      match_offset_q <= 16'h0000;
    end else begin
      off_q          <= off_d;
      match_offset_q <= match_offset_d;
    end
  end

  assign io.match_offset = match_offset_q;
`else
  assign io.match_offset = 16'h0000;
`endif

  assign io.s_rdy         = s_rdy;
  assign io.dfa_char      = dfa_char_q;
  assign io.dfa_char_vld  = dfa_char_vld_q;
  assign io.dfa_state     = dfa_state_q;
  assign io.dfa_state_vld = dfa_state_vld_q;
  assign io.match_vld     = match_vld_q;
  assign io.match_flow    = match_flow_q;
  assign io.busy          = busy_q;
endmodule
